// File: rtl/riscv_mul_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_mul_div_ctrl: RV32M sequencer around an unsigned mul/div core.      |
// | Optional one-entry division result cache: define MUL_DIV_RESULT_CACHE_EN. |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module riscv_mul_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        core_enable_in,
  output logic [31:0] core_x,
  output logic [31:0] core_y,
  output logic        core_mul0_div1,
  output logic        core_x_unsigned,
  output logic        core_y_unsigned,
  input  logic        core_enable_out,
  input  logic [63:0] core_z,
  input  logic [31:0] core_q,
  input  logic [31:0] core_r
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

  function automatic logic x_is_signed(input logic [2:0] f);
    return (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
  endfunction

  function automatic logic y_is_signed(input logic [2:0] f);
    return (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
  endfunction

  state_t      state;
  state_t      next_state;

  logic [2:0]  op_r;
  logic [31:0] x_r;
  logic [31:0] y_r;
  logic        dz_r;
  logic        ovf_r;
  logic        hit_r;
  logic [63:0] z_r;
  logic [31:0] q_r;
  logic [31:0] r_r;

  logic        in_is_div;
  logic        in_dz;
  logic        in_ovf;
  logic        in_hit;
  logic [31:0] hit_quo;
  logic [31:0] hit_rem;

  logic        sign_x;
  logic        sign_y;
  logic [31:0] mag_x;
  logic [31:0] mag_y;
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] fix_result;

  // Request decode on the raw inputs, used only when a start is accepted.
  assign in_is_div = funct3[2];
  assign in_dz     = in_is_div & (rs2 == 32'd0);
  assign in_ovf    = in_is_div & ~funct3[0] & (rs1 == INT_MIN) & (rs2 == ALL_ONE);

`ifdef MUL_DIV_RESULT_CACHE_EN
  logic [31:0] cache_x;
  logic [31:0] cache_y;
  logic        cache_signed;
  logic [31:0] cache_quo;
  logic [31:0] cache_rem;
  logic        cache_valid;

  assign in_hit  = in_is_div & cache_valid & (rs1 == cache_x) & (rs2 == cache_y)
                 & (cache_signed == ~funct3[0]);
  assign hit_quo = cache_quo;
  assign hit_rem = cache_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_x      <= 32'd0;
      cache_y      <= 32'd0;
      cache_signed <= 1'b0;
      cache_quo    <= 32'd0;
      cache_rem    <= 32'd0;
      cache_valid  <= 1'b0;
    end else if (state == S_FIX && op_r[2] && !dz_r && !ovf_r && !hit_r) begin
      cache_x      <= x_r;
      cache_y      <= y_r;
      cache_signed <= ~op_r[0];
      cache_quo    <= quo_fixed;
      cache_rem    <= rem_fixed;
      cache_valid  <= 1'b1;
    end
  end
`else
  assign in_hit  = 1'b0;
  assign hit_quo = 32'd0;
  assign hit_rem = 32'd0;
`endif

  // The core only sees magnitudes; signs are reapplied in FIX.
  assign sign_x     = x_is_signed(op_r) & x_r[31];
  assign sign_y     = y_is_signed(op_r) & y_r[31];
  assign mag_x      = sign_x ? (~x_r + 32'd1) : x_r;
  assign mag_y      = sign_y ? (~y_r + 32'd1) : y_r;
  assign prod_fixed = (sign_x ^ sign_y) ? (~z_r + 64'd1) : z_r;
  assign quo_fixed  = (sign_x ^ sign_y) ? (~q_r + 32'd1) : q_r;
  assign rem_fixed  = sign_x ? (~r_r + 32'd1) : r_r;

  always_comb begin
    fix_result = 32'd0;
    if (dz_r) begin
      fix_result = op_r[1] ? x_r : ALL_ONE;
    end else if (ovf_r) begin
      fix_result = op_r[1] ? 32'd0 : INT_MIN;
    end else if (hit_r) begin
      fix_result = op_r[1] ? hit_rem : hit_quo;
    end else if (op_r[2]) begin
      fix_result = op_r[1] ? rem_fixed : quo_fixed;
    end else if (op_r == 3'd0) begin
      fix_result = prod_fixed[31:0];
    end else begin
      fix_result = prod_fixed[63:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state      = state;
    busy            = (state != S_IDLE);
    done            = 1'b0;
    core_enable_in  = 1'b0;
    core_x          = 32'd0;
    core_y          = 32'd0;
    core_mul0_div1  = 1'b0;
    core_x_unsigned = 1'b0;
    core_y_unsigned = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = (in_dz || in_ovf || in_hit) ? S_FIX : S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_enable_in  = 1'b1;
        core_x          = mag_x;
        core_y          = mag_y;
        core_mul0_div1  = op_r[2];
        core_x_unsigned = 1'b1;
        core_y_unsigned = 1'b1;
        next_state      = S_WAIT;
      end
      S_WAIT: begin
        if (core_enable_out) begin
          next_state = S_FIX;
        end
      end
      S_FIX: begin
        next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r   <= 3'd0;
      x_r    <= 32'd0;
      y_r    <= 32'd0;
      dz_r   <= 1'b0;
      ovf_r  <= 1'b0;
      hit_r  <= 1'b0;
      z_r    <= 64'd0;
      q_r    <= 32'd0;
      r_r    <= 32'd0;
      result <= 32'd0;
    end else begin
      if (state == S_IDLE && start) begin
        op_r  <= funct3;
        x_r   <= rs1;
        y_r   <= rs2;
        dz_r  <= in_dz;
        ovf_r <= in_ovf;
        hit_r <= in_hit & ~in_dz & ~in_ovf;
      end
      if (state == S_WAIT && core_enable_out) begin
        z_r <= core_z;
        q_r <= core_q;
        r_r <= core_r;
      end
      if (state == S_FIX) begin
        result <= fix_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mul_div_ctrl.sv
`default_nettype none
// Bench for riscv_mul_div_ctrl: directed RV32M corner cases plus random ops,
// with a latency-programmable core model and an arithmetic reference.
module tb_riscv_mul_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        core_enable_in;
  logic [31:0] core_x;
  logic [31:0] core_y;
  logic        core_mul0_div1;
  logic        core_x_unsigned;
  logic        core_y_unsigned;
  logic        core_enable_out = 1'b0;
  logic [63:0] core_z = 64'd0;
  logic [31:0] core_q = 32'd0;
  logic [31:0] core_r = 32'd0;

  int errors = 0;
  int checks = 0;
  int core_lat = 1;
  int cnt = 0;
  int ein_cnt = 0;
  logic [31:0] cap_x = 32'd0;
  logic [31:0] cap_y = 32'd0;
  logic        cap_md = 1'b0;
  logic        cap_xu = 1'b0;
  logic        cap_yu = 1'b0;

  bit          mc_valid = 1'b0;
  logic [31:0] mc_a = 32'd0;
  logic [31:0] mc_b = 32'd0;
  bit          mc_s = 1'b0;

  logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

  always #5 clk = ~clk;

  riscv_mul_div_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result),
    .core_enable_in(core_enable_in), .core_x(core_x), .core_y(core_y),
    .core_mul0_div1(core_mul0_div1), .core_x_unsigned(core_x_unsigned),
    .core_y_unsigned(core_y_unsigned), .core_enable_out(core_enable_out),
    .core_z(core_z), .core_q(core_q), .core_r(core_r)
  );

  // Unsigned core: enable_out arrives core_lat cycles after the enable_in cycle.
  always @(posedge clk) begin
    core_enable_out <= 1'b0;
    if (core_enable_in) begin
      core_z <= {32'd0, core_x} * {32'd0, core_y};
      core_q <= (core_y == 32'd0) ? 32'hFFFF_FFFF : core_x / core_y;
      core_r <= (core_y == 32'd0) ? core_x : core_x % core_y;
      if (core_lat <= 1) core_enable_out <= 1'b1;
      else cnt <= core_lat - 1;
    end else if (cnt > 0) begin
      if (cnt == 1) core_enable_out <= 1'b1;
      cnt <= cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (core_enable_in) begin
      ein_cnt <= ein_cnt + 1;
      cap_x   <= core_x;
      cap_y   <= core_y;
      cap_md  <= core_mul0_div1;
      cap_xu  <= core_x_unsigned;
      cap_yu  <= core_y_unsigned;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] res;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    res = 32'd0;
    p   = 64'd0;
    case (f)
      3'd0: begin p = 64'(sa * sb); res = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); res = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); res = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) res = 32'hFFFF_FFFF;
        else if (ovf)   res = 32'h8000_0000;
        else begin p = 64'(sa / sb); res = p[31:0]; end
      end
      3'd5: res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) res = a;
        else if (ovf)   res = 32'd0;
        else begin p = 64'(sa % sb); res = p[31:0]; end
      end
      default: res = (b == 32'd0) ? a : a % b;
    endcase
    return res;
  endfunction

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input bit poke);
    logic [31:0] exp_res, ex, ey;
    bit is_div, dz, ovf, hit, exp_issue, xs, ys;
    int cyc, e0;
    is_div  = f[2];
    dz      = is_div && (b == 32'd0);
    ovf     = is_div && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    hit     = 1'b0;
`ifdef MUL_DIV_RESULT_CACHE_EN
    hit     = is_div && !dz && !ovf && mc_valid && (mc_a == a) && (mc_b == b) && (mc_s == !f[0]);
`endif
    exp_issue = !(dz || ovf || hit);
    exp_res   = ref_result(f, a, b);
    xs = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    ys = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    ex = (xs && a[31]) ? -a : a;
    ey = (ys && b[31]) ? -b : b;

    core_lat = lat;
    e0       = ein_cnt;
    funct3   = f;
    rs1      = a;
    rs2      = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 1) begin
        start  = 1'b1;
        funct3 = ~f;
        rs1    = $urandom;
        rs2    = $urandom;
      end else begin
        start = 1'b0;
      end
    end while (!done && cyc < 60);

    check("done_timeout", 64'(!done), 64'd0);
    check($sformatf("result f%0d %h,%h", f, a, b), 64'(result), 64'(exp_res));
    check("done_latency", 64'(cyc), exp_issue ? 64'(lat + 3) : 64'd2);
    check("core_issues", 64'(ein_cnt - e0), 64'(exp_issue));
    if (exp_issue) begin
      check("core_x", 64'(cap_x), 64'(ex));
      check("core_y", 64'(cap_y), 64'(ey));
      check("core_mul0_div1", 64'(cap_md), 64'(f[2]));
      check("core_unsigned", 64'({cap_xu, cap_yu}), 64'd3);
    end
    if (poke) begin
      start  = 1'b1;
      funct3 = 3'd0;
      rs1    = $urandom;
      rs2    = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
`ifdef MUL_DIV_RESULT_CACHE_EN
    if (is_div && exp_issue) begin
      mc_valid = 1'b1;
      mc_a     = a;
      mc_b     = b;
      mc_s     = !f[0];
    end
`endif
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    if ($urandom_range(0, 2) == 0) v = corners[$urandom_range(0, 5)];
    else v = $urandom;
    return v;
  endfunction

  initial begin
    bit saw_done;
    logic [2:0] rf;
    logic [31:0] ra, rb;
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    rs1    = 32'd0;
    rs2    = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_core_enable_in", 64'(core_enable_in), 64'd0);
    check("rst_core_x", 64'(core_x), 64'd0);
    check("rst_core_y", 64'(core_y), 64'd0);
    check("rst_core_flags", 64'({core_mul0_div1, core_x_unsigned, core_y_unsigned}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 2, 1'b0);
    do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 1, 1'b1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 4, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 2, 1'b1);
    do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
    do_op(3'd5, 32'd5, 32'd0, 3, 1'b1);
    do_op(3'd7, 32'd5, 32'd0, 3, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0);
    do_op(3'd4, 32'd100, 32'd7, 2, 1'b0);
    do_op(3'd6, 32'd100, 32'd7, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      do_op(rf, ra, rb, $urandom_range(1, 4), ($urandom_range(0, 3) == 0));
    end

    // Abort a division in WAIT; the core still answers after reset is released.
    core_lat = 8;
    funct3   = 3'd4;
    rs1      = 32'd1000;
    rs2      = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    mc_valid = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    do_op(3'd0, 32'd3, 32'd4, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
